rr_arbiter8: RTL
================

# rr_arbiter8

Eight-way round-robin arbiter that shares a single downstream resource between eight requesters. It issues a registered one-hot grant and its 3-bit encoded index, holds the grant until the owner finishes or a hold limit expires, then rotates priority. It sits in front of the shared datapath and drives both its select lines and its valid qualifier.

## Interface
- `HOLD_MAX`, default 16: maximum cycles one grant may be held; 0 disables the limit.
- `CNT_W`, default 5: hold-counter width; must hold `HOLD_MAX`.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `en`, input, 1: arbitration enable; when 0, no new grant is issued.
- `req`, input, 8: request vector; bit i is requester i.
- `done`, input, 1: the current owner releases the grant; sampled only in BUSY.
- `gnt`, output, 8: registered one-hot grant, or all zeros.
- `gnt_idx`, output, 3: binary index of the set bit in `gnt`; holds its last value when `gnt` is 0.
- `gnt_vld`, output, 1: 1 exactly when `gnt` is nonzero.
- `timeout`, output, 1: one-cycle pulse when a grant is force-released by `HOLD_MAX`.

## Operation
- **States**
  - IDLE: no grant.
  - BUSY: one owner holds the grant.
- **Priority pointer `ptr` (3 bits)**
  - Search order is `ptr`, `ptr+1`, …, `ptr+7`, modulo 8.
  - The first set bit of `req` in that order wins.
- **IDLE → BUSY**
  - Condition: `en`=1 and `req`≠0 at the clock edge.
  - Register `gnt` = one-hot of the winner, `gnt_idx` = winner index, `gnt_vld`=1.
  - Clear the hold counter `cnt` to 0.
- **BUSY, each edge:** evaluate in this priority order.
  1. `done`=1: release.
  2. `req[owner]`=0 (owner dropped its request): release.
  3. `HOLD_MAX`≠0 and `cnt`==`HOLD_MAX`-1: release and pulse `timeout`=1 for the next cycle.
  4. Otherwise: increment `cnt`; the grant is unchanged.
- **Release**
  - Go to IDLE; `gnt`=0, `gnt_vld`=0.
  - `ptr` ← owner+1, modulo 8 (7 wraps to 0).
- **`en`** gates only IDLE→BUSY; an active grant continues regardless of `en`.
- **Requests from other requesters** while BUSY have no effect on the current grant.

## Timing
- **Reset values:** `gnt`=0, `gnt_idx`=0, `gnt_vld`=0, `timeout`=0, `ptr`=0, `cnt`=0, state IDLE.
- **Grant latency:** `req` seen at edge t in IDLE → `gnt` valid immediately after edge t, i.e. one cycle from request assertion.
- **Release:** `done` sampled high at edge u clears `gnt` after edge u.
- **Mandatory bubble:** IDLE lasts at least one cycle between grants, so the earliest next grant is after edge u+1.
- **Hold limit:**
  - A grant with no release lasts exactly `HOLD_MAX` cycles.
  - `timeout` is high in the first IDLE cycle after the forced release.
- **Simultaneous events:** `done`=1 in the same cycle as hold expiry counts as a normal release, with no `timeout` pulse.
- **Reset mid-grant:** asynchronously forces all reset values, including `ptr`=0; there is no partial-state recovery.
- **Output behaviour:** all outputs are registered, with no combinational input-to-output path.

## Structure
- **Shared package `arb_pkg`**
  - State enum {IDLE, BUSY}.
  - `N_REQ`=8 and `IDX_W`=3.
- **Sub-module `onehot_enc8`**
  - 8-bit one-hot to 3-bit index, plus valid.
  - Used to encode the rotated winner.
- **Winner search:** rotate `req` right by `ptr`, take the lowest set bit, then add `ptr` modulo 8.

## Test plan
- **Reset:** assert `rst_n`=0 mid-grant → all outputs 0 asynchronously; after release, `req`=8'h80 grants index 7 (`ptr`=0 search).
- **Rotation:** hold `req`=8'hFF and pulse `done` one cycle after every grant → grant sequence 0,1,…,7,0 with `gnt_idx` matching and one IDLE cycle between grants.
- **Wrap and skip:**
  - After owner 6 releases, `req`=8'h41 → grant index 0, since the search starts at 7 and wraps.
  - Then `req`=8'h40 → index 6.
- **Timeout:** `HOLD_MAX`=4, `req`=8'h04, no `done` → `gnt`=8'h04 for exactly 4 cycles, then `timeout`=1 for 1 cycle; the next grant goes to 2 again only after the bubble.
- **Simultaneous events:**
  - `done`=1 in the cycle `cnt`==`HOLD_MAX`-1 → release with `timeout`=0.
  - Owner drops `req` mid-grant → release on that edge.
- **Enable:**
  - `en`=0 with `req`=8'h10 → no grant.
  - Drop `en` during a grant → the grant persists until `done`.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and sizes for the eight-way round-robin arbiter.
package arb_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;
endpackage

// File: rtl/onehot_enc8.sv
// One-hot to binary encoder; o_vld flags a nonzero input.
module onehot_enc8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_vld
);

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i_onehot[i]) begin
                o_idx = o_idx | IDX_W'(i);
            end
        end
    end

    assign o_vld = |i_onehot;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant, encoded index
// and an optional hold limit that force-releases a stuck owner.
//
// state | meaning
// IDLE  | no grant; a new winner may be picked when en=1 and req!=0
// BUSY  | one owner holds the grant until done, request drop or hold limit
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             timeout
);

    localparam logic             LP_LIMIT_EN = (HOLD_MAX != 0);
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(HOLD_MAX - 1);

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [N_REQ-1:0] r_gnt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic             r_gnt_vld;
    logic             r_timeout;

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [N_REQ-1:0]   w_lsb;
    logic [IDX_W-1:0]   w_rot_idx;
    logic               w_rot_vld;
    logic [IDX_W-1:0]   w_win_idx;
    logic [N_REQ-1:0]   w_win_oh;
    logic               w_owner_req;
    logic               w_at_limit;

    // Rotate right by ptr so the highest-priority requester lands at bit 0.
    assign w_dbl = {req, req} >> r_ptr;
    assign w_rot = w_dbl[N_REQ-1:0];
    assign w_lsb = w_rot & (~w_rot + N_REQ'(1));

    onehot_enc8 u_enc (
        .i_onehot (w_lsb),
        .o_idx    (w_rot_idx),
        .o_vld    (w_rot_vld)
    );

    assign w_win_idx   = w_rot_idx + r_ptr;
    assign w_win_oh    = N_REQ'(1) << w_win_idx;
    assign w_owner_req = req[r_gnt_idx];
    assign w_at_limit  = LP_LIMIT_EN && (r_cnt == LP_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_gnt_vld <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en && w_rot_vld) begin
                        r_state   <= BUSY;
                        r_gnt     <= w_win_oh;
                        r_gnt_idx <= w_win_idx;
                        r_gnt_vld <= 1'b1;
                        r_cnt     <= '0;
                    end
                end
                BUSY: begin
                    // done and request drop outrank the hold limit, so a
                    // coincident done never produces a timeout pulse.
                    if (done || !w_owner_req || w_at_limit) begin
                        r_state   <= IDLE;
                        r_gnt     <= '0;
                        r_gnt_vld <= 1'b0;
                        r_ptr     <= r_gnt_idx + IDX_W'(1);
                        r_timeout <= !done && w_owner_req;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign gnt_idx = r_gnt_idx;
    assign gnt_vld = r_gnt_vld;
    assign timeout = r_timeout;

endmodule
